// File: rtl/rx_frame_monitor_pkg.sv
// rx_frame_monitor_pkg: shared state encodings, sequence threshold and vldb mapping
package rx_frame_monitor_pkg;
  typedef enum logic {IDLE, BODY} frm_state_t;
  typedef enum logic {HUNT, LOCK} seq_state_t;
  localparam int SEQ_ERR_LIMIT = 3;
  function automatic logic [2:0] vldb_bytes(input logic [1:0] v);
    return v == 2'd0 ? 3'd4 : {1'b0, v};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating accumulator with synchronous clear that merges with a same-cycle increment
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] count_q
);
  logic [W-1:0] base;
  logic [W:0]   sum;
  logic [W-1:0] count_d;
  always_comb begin
    base    = clr ? '0 : count_q;
    sum     = {1'b0, base} + {1'b0, inc};
    count_d = en ? (sum[W] ? '1 : sum[W-1:0]) : base;
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/rx_frame_monitor.sv
// rx_frame_monitor: RX AXIS frame/byte/error statistics with sequence tracking and snapshot outputs
module rx_frame_monitor
  import rx_frame_monitor_pkg::*;
#(
  parameter int P_CNT_W        = 32,
  parameter int P_MIN_BYTES    = 64,
  parameter int P_MAX_BYTES    = 1518,
  parameter int P_CLR_ON_LATCH = 1
) (
  input  logic               rx_user_clk_i,
  input  logic               rx_user_rst_i,
  input  logic [31:0]        rx_data_i,
  input  logic [1:0]         rx_vldb_i,
  input  logic               rx_valid_i,
  input  logic               rx_last_i,
  input  logic               rx_user_i,
  input  logic               stat_latch_i,
  output logic [P_CNT_W-1:0] frame_cnt_o,
  output logic [P_CNT_W-1:0] err_frame_cnt_o,
  output logic [P_CNT_W-1:0] seq_err_cnt_o,
  output logic [P_CNT_W-1:0] runt_cnt_o,
  output logic [P_CNT_W-1:0] giant_cnt_o,
  output logic [47:0]        byte_cnt_o,
  output logic               stat_valid_o,
  output logic               seq_lock_o
);
  localparam logic [15:0] MIN_L = 16'(P_MIN_BYTES);
  localparam logic [15:0] MAX_L = 16'(P_MAX_BYTES);
  localparam logic [1:0]  MIS_LAST = 2'(SEQ_ERR_LIMIT - 1);
  frm_state_t frm_q, frm_d;
  seq_state_t seq_q, seq_d;
  logic [15:0] len_q, len_d, len_end;
  logic [16:0] len_sum;
  logic [31:0] exp_q, exp_d;
  logic [1:0]  mis_q, mis_d;
  logic        first, fend, seq_err, clr;
  logic [4:0]  ev;
  logic [4:0][P_CNT_W-1:0] live, snap_q, snap_d;
  logic [47:0] byte_live, byte_snap_q, byte_snap_d;
  logic        stat_valid_q;
  always_comb begin
    first       = rx_valid_i && frm_q == IDLE;
    fend        = rx_valid_i && rx_last_i;
    len_sum     = {1'b0, len_q} + {14'b0, rx_last_i ? vldb_bytes(rx_vldb_i) : 3'd4};
    len_end     = len_sum[16] ? '1 : len_sum[15:0];
    len_d       = rx_valid_i ? (rx_last_i ? '0 : len_end) : len_q;
    frm_d       = rx_valid_i ? (rx_last_i ? IDLE : BODY) : frm_q;
    seq_err     = first && seq_q == LOCK && rx_data_i != exp_q;
    exp_d       = first ? ((seq_q == LOCK && !seq_err) ? exp_q + 32'd1 : rx_data_i + 32'd1) : exp_q;
    mis_d       = first ? ((seq_err && mis_q != MIS_LAST) ? mis_q + 2'd1 : 2'd0) : mis_q;
    seq_d       = first ? ((seq_err && mis_q == MIS_LAST) ? HUNT : LOCK) : seq_q;
    clr         = stat_latch_i && P_CLR_ON_LATCH != 0;
    ev          = {fend && len_end > MAX_L, fend && len_end < MIN_L, seq_err, fend && rx_user_i, fend};
    snap_d      = stat_latch_i ? live : snap_q;
    byte_snap_d = stat_latch_i ? byte_live : byte_snap_q;
  end
  for (genvar i = 0; i < 5; i++) begin : g_cnt
    sat_counter #(.W(P_CNT_W)) u_cnt (
      .clk(rx_user_clk_i), .rst(rx_user_rst_i), .clr(clr), .en(ev[i]),
      .inc(P_CNT_W'(1)), .count_q(live[i])
    );
  end
  sat_counter #(.W(48)) u_byte (
    .clk(rx_user_clk_i), .rst(rx_user_rst_i), .clr(clr), .en(fend),
    .inc({32'b0, len_end}), .count_q(byte_live)
  );
  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      frm_q        <= IDLE;
      seq_q        <= HUNT;
      len_q        <= '0;
      exp_q        <= '0;
      mis_q        <= '0;
      snap_q       <= '0;
      byte_snap_q  <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      frm_q        <= frm_d;
      seq_q        <= seq_d;
      len_q        <= len_d;
      exp_q        <= exp_d;
      mis_q        <= mis_d;
      snap_q       <= snap_d;
      byte_snap_q  <= byte_snap_d;
      stat_valid_q <= stat_latch_i;
    end
  end
  assign frame_cnt_o     = snap_q[0];
  assign err_frame_cnt_o = snap_q[1];
  assign seq_err_cnt_o   = snap_q[2];
  assign runt_cnt_o      = snap_q[3];
  assign giant_cnt_o     = snap_q[4];
  assign byte_cnt_o      = byte_snap_q;
  assign stat_valid_o    = stat_valid_q;
  assign seq_lock_o      = seq_q == LOCK;
endmodule

// File: tb/tb_rx_frame_monitor.sv
// tb_rx_frame_monitor: directed scoreboard bench for rx_frame_monitor
module tb_rx_frame_monitor;
  localparam int CW = 5;
  localparam int CMAX = 31;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] rx_data_i = '0;
  logic [1:0] rx_vldb_i = '0;
  logic rx_valid_i = 0, rx_last_i = 0, rx_user_i = 0, stat_latch_i = 0;
  logic [CW-1:0] frame_cnt_o, err_frame_cnt_o, seq_err_cnt_o, runt_cnt_o, giant_cnt_o;
  logic [47:0] byte_cnt_o;
  logic stat_valid_o, seq_lock_o;
  int vectors = 0, miscompares = 0;
  typedef struct {int f; int e; int s; int r; int g; longint b;} snap_t;
  snap_t sbq[$];
  int m_f, m_e, m_s, m_r, m_g, m_mis;
  longint m_b;
  logic m_lock;
  logic [31:0] m_exp;
  rx_frame_monitor #(.P_CNT_W(CW)) dut (
    .rx_user_clk_i(clk), .rx_user_rst_i(rst), .rx_data_i(rx_data_i), .rx_vldb_i(rx_vldb_i),
    .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i), .rx_user_i(rx_user_i), .stat_latch_i(stat_latch_i),
    .frame_cnt_o(frame_cnt_o), .err_frame_cnt_o(err_frame_cnt_o), .seq_err_cnt_o(seq_err_cnt_o),
    .runt_cnt_o(runt_cnt_o), .giant_cnt_o(giant_cnt_o), .byte_cnt_o(byte_cnt_o),
    .stat_valid_o(stat_valid_o), .seq_lock_o(seq_lock_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1);
  end
  function automatic int sat(input int x);
    return x > CMAX ? CMAX : x;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mreset();
    {m_f, m_e, m_s, m_r, m_g, m_mis} = '0;
    m_b = 0;
    m_lock = 0;
    m_exp = '0;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    mreset();
  endtask
  task automatic push_snap();
    sbq.push_back('{m_f, m_e, m_s, m_r, m_g, m_b});
    {m_f, m_e, m_s, m_r, m_g} = '0;
    m_b = 0;
  endtask
  task automatic model_frame(input logic [31:0] seq, input int n, input logic user);
    if (!m_lock) begin
      m_exp = seq + 1;
      m_lock = 1;
      m_mis = 0;
    end else if (seq == m_exp) begin
      m_exp = m_exp + 1;
      m_mis = 0;
    end else begin
      m_s = sat(m_s + 1);
      m_exp = seq + 1;
      m_mis++;
      if (m_mis == 3) begin
        m_lock = 0;
        m_mis = 0;
      end
    end
    m_f = sat(m_f + 1);
    m_b += n;
    if (user) m_e = sat(m_e + 1);
    if (n < 64) m_r = sat(m_r + 1);
    if (n > 1518) m_g = sat(m_g + 1);
  endtask
  task automatic check_snap();
    snap_t x;
    int w = 0;
    while (!stat_valid_o && w < 4) begin
      step();
      w++;
    end
    chk("stat_valid", stat_valid_o, 1);
    x = sbq.pop_front();
    chk("frame_cnt", frame_cnt_o, x.f);
    chk("err_frame_cnt", err_frame_cnt_o, x.e);
    chk("seq_err_cnt", seq_err_cnt_o, x.s);
    chk("runt_cnt", runt_cnt_o, x.r);
    chk("giant_cnt", giant_cnt_o, x.g);
    chk("byte_cnt", byte_cnt_o, x.b);
    step();
    chk("stat_valid_pulse", stat_valid_o, 0);
  endtask
  task automatic latch();
    stat_latch_i = 1;
    push_snap();
    step();
    stat_latch_i = 0;
    check_snap();
  endtask
  task automatic send_frame(input logic [31:0] seq, input int n, input logic user,
                            input logic lat, input logic gaps);
    int nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      if (gaps && b == 1) begin
        rx_valid_i = 0;
        rx_last_i = 1;
        rx_vldb_i = 2'd1;
        rx_data_i = $urandom;
        step();
        step();
      end
      rx_valid_i = 1;
      rx_last_i = b == nb - 1;
      rx_data_i = b == 0 ? seq : $urandom;
      rx_vldb_i = rx_last_i ? 2'(n % 4) : 2'($urandom);
      rx_user_i = rx_last_i ? user : 1'($urandom);
      stat_latch_i = lat && rx_last_i;
      step();
    end
    rx_valid_i = 0;
    rx_last_i = 0;
    stat_latch_i = 0;
    rx_user_i = 0;
    if (lat) push_snap();
    model_frame(seq, n, user);
    if (lat) check_snap();
    chk("seq_lock", seq_lock_o, m_lock);
  endtask
  initial begin
    mreset();
    step();
    step();
    rst = 0;
    chk("rst_frame", frame_cnt_o, 0);
    chk("rst_err", err_frame_cnt_o, 0);
    chk("rst_seq_err", seq_err_cnt_o, 0);
    chk("rst_runt", runt_cnt_o, 0);
    chk("rst_giant", giant_cnt_o, 0);
    chk("rst_byte", byte_cnt_o, 0);
    chk("rst_valid", stat_valid_o, 0);
    chk("rst_lock", seq_lock_o, 0);
    for (int i = 0; i < 10; i++) send_frame(i, 64, 0, 0, 0);
    latch();
    chk("ten_lock", seq_lock_o, 1);
    send_frame(10, 2, 0, 0, 0);
    latch();
    do_reset();
    send_frame(5, 64, 0, 0, 0);
    send_frame(6, 64, 0, 0, 0);
    send_frame(9, 64, 0, 0, 0);
    send_frame(10, 64, 0, 0, 0);
    latch();
    chk("gap_seq_lock", seq_lock_o, 1);
    send_frame(100, 64, 0, 0, 0);
    send_frame(200, 64, 0, 0, 0);
    send_frame(300, 64, 0, 0, 0);
    chk("three_bad_unlock", seq_lock_o, 0);
    latch();
    do_reset();
    send_frame(32'hFFFF_FFFF, 64, 0, 0, 0);
    send_frame(0, 100, 0, 1, 0);
    latch();
    rx_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data_i = $urandom;
      step();
    end
    rx_valid_i = 0;
    do_reset();
    send_frame(77, 64, 0, 0, 1);
    latch();
    send_frame(78, 1600, 1, 0, 1);
    latch();
    for (int i = 0; i < 35; i++) send_frame(79 + i, 4, 0, 0, 0);
    latch();
    send_frame(114, 7, 0, 0, 0);
    latch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rx_frame_monitor.md
RX_FRAME_MONITOR -- requirements
Module: rx_frame_monitor

Interface
- REQ-001 Parameter P_CNT_W, default 32: width of the frame and error counters.
- REQ-002 Parameter P_MIN_BYTES, default 64: frames shorter than this are runts.
- REQ-003 Parameter P_MAX_BYTES, default 1518: frames longer than this are giants.
- REQ-004 Parameter P_CLR_ON_LATCH, default 1: live counters clear when a snapshot is taken.
- REQ-005 rx_user_clk_i  in  1  sole clock; the RX user clock from pcs_top.
- REQ-006 rx_user_rst_i  in  1  reset; synchronous, active-high.
- REQ-007 rx_data_i  in  32  RX AXIS data; byte 0 is in [7:0].
- REQ-008 rx_vldb_i  in  2  valid bytes on the last beat: 0 means 4, 1-3 mean 1-3; ignored on non-last beats.
- REQ-009 rx_valid_i  in  1  beat qualifier; there is no backpressure.
- REQ-010 rx_last_i  in  1  marks the final beat of a frame.
- REQ-011 rx_user_i  in  1  PCS error flag; sampled on the last beat only.
- REQ-012 stat_latch_i  in  1  one-cycle snapshot request.
- REQ-013 frame_cnt_o, err_frame_cnt_o, seq_err_cnt_o, runt_cnt_o, giant_cnt_o  out  P_CNT_W each  snapshot counters.
- REQ-014 byte_cnt_o  out  48  snapshot byte count.
- REQ-015 stat_valid_o  out  1  one-cycle pulse when the snapshot outputs update.
- REQ-016 seq_lock_o  out  1  sequence tracker is locked.

Function
- REQ-017 A beat is accepted when rx_valid_i=1; a beat with rx_valid_i=0 changes no state.
- REQ-018 The frame state machine has states IDLE and BODY.
  - IDLE -> BODY on an accepted beat with rx_last_i=0.
  - BODY -> IDLE on an accepted beat with rx_last_i=1.
  - An accepted last beat in IDLE is a complete single-beat frame.
- REQ-019 The first beat of every frame carries a 32-bit sequence number in rx_data_i.
- REQ-020 Frame length is counted per frame in a 16-bit register that saturates at 0xFFFF.
  - Non-last beats add 4 bytes; the last beat adds the rx_vldb_i byte count.
- REQ-021 At each frame end, these live counters update on the same clock edge:
  - frame_cnt +1;
  - byte_cnt + frame length;
  - err_frame_cnt +1 if rx_user_i=1;
  - runt_cnt +1 if length < P_MIN_BYTES;
  - giant_cnt +1 if length > P_MAX_BYTES.
- REQ-022 All counters saturate at their all-ones value and never wrap.
- REQ-023 The sequence tracker has states HUNT and LOCK.
  - HUNT: the first-beat sequence number is loaded and expected = seq+1; go to LOCK.
  - LOCK, match: expected +1 and the mismatch run clears.
  - LOCK, mismatch: seq_err_cnt +1, expected = received+1, and the mismatch run +1.
  - Three consecutive mismatches return the tracker to HUNT.
- REQ-024 seq_lock_o=1 exactly while the tracker is in LOCK; expected wraps modulo 2^32 (0xFFFFFFFF is followed by 0).
- REQ-025 On stat_latch_i, all live counters are copied to the outputs, and stat_valid_o pulses on the next cycle together with the new output values.
- REQ-026 When P_CLR_ON_LATCH=1, live counters clear on latch. If a frame ends in the same cycle:
  - the snapshot excludes that frame;
  - the live counters equal that frame's increments only.
- REQ-027 When P_CLR_ON_LATCH=0, a latch coincident with a frame end likewise snapshots the pre-update values.

Reset
- REQ-028 Reset returns the following to zero / initial state:
  - all live counters, snapshot outputs, stat_valid_o and seq_lock_o read 0;
  - the frame FSM returns to IDLE and the tracker to HUNT;
  - the length and mismatch registers read 0.
- REQ-029 A frame in progress at reset is discarded and never counted; beats after reset deassertion up to the next rx_last_i are treated as a new frame.

Structure
- REQ-030 A shared package holds the FSM state encodings, the 3-mismatch threshold, and the vldb-to-byte-count mapping.
- REQ-031 A single saturating-counter sub-module, sat_counter, holds the increment, clear and saturation logic and is instantiated once per counter.

Verification
- REQ-032 Ten 64-byte frames, seq 0..9, then a latch -> frame=10, byte=640, seq_err=0, runt=0, seq_lock_o=1.
- REQ-033 Single-beat frame with vldb=2 -> length 2 and runt=1; the frame carries a sequence number but has no BODY state.
- REQ-034 Seq 5, 6, 9, 10 -> seq_err=1 and lock is held; three consecutive bad sequence numbers -> seq_lock_o=0.
- REQ-035 Latch coincident with a 100-byte frame end, P_CLR_ON_LATCH=1 -> the snapshot excludes it; the next latch shows frame=1, byte=100.
- REQ-036 Reset mid-frame, then a complete 64-byte frame -> frame=1; rx_valid_i gaps inside a frame do not alter its length.
- REQ-037 A 1600-byte frame with rx_user_i=1 -> giant=1, err_frame=1; forcing a counter to all-ones -> it stays at all-ones.
